// File: rtl/spw_link_fsm_if.sv
// Signal bundle between the SpaceWire link-initialisation FSM, the host
// registers and the RX/TX pair; the FSM takes the slave view.
interface spw_link_fsm_if;
    logic       link_start;
    logic       auto_start;
    logic       link_disable;
    logic       rx_got_bit;
    logic       rx_got_null;
    logic       rx_got_fct;
    logic       rx_got_nchar;
    logic       rx_got_time_code;
    logic       rx_error;
    logic       credit_error;
    logic       rx_resetn;
    logic       enable_tx;
    logic       send_null_tx;
    logic       send_fct_tx;
    logic       link_run;
    logic [2:0] fsm_state;
    logic       link_error;

    modport master (
        output link_start, auto_start, link_disable,
        output rx_got_bit, rx_got_null, rx_got_fct, rx_got_nchar,
        output rx_got_time_code, rx_error, credit_error,
        input  rx_resetn, enable_tx, send_null_tx, send_fct_tx,
        input  link_run, fsm_state, link_error
    );

    modport slave (
        input  link_start, auto_start, link_disable,
        input  rx_got_bit, rx_got_null, rx_got_fct, rx_got_nchar,
        input  rx_got_time_code, rx_error, credit_error,
        output rx_resetn, enable_tx, send_null_tx, send_fct_tx,
        output link_run, fsm_state, link_error
    );
endinterface

// File: rtl/spw_link_fsm.sv
// SpaceWire exchange-level link-initialisation FSM: sequences RX reset and TX
// mode from receiver status pulses, with disconnect detection and timeouts.
module spw_link_fsm #(
    parameter int T_6US4  = 64,
    parameter int T_12US8 = 128,
    parameter int T_DISC  = 9,
    parameter int CNT_W   = 8
) (
    input  logic          pclk,
    input  logic          resetn,
    spw_link_fsm_if.slave lnk
);

    typedef enum logic [2:0] {
        ERROR_RESET = 3'd0,
        ERROR_WAIT  = 3'd1,
        READY       = 3'd2,
        STARTED     = 3'd3,
        CONNECTING  = 3'd4,
        RUN         = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0] C_T6_LAST  = CNT_W'(T_6US4 - 1);
    localparam logic [CNT_W-1:0] C_T12_LAST = CNT_W'(T_12US8 - 1);
    localparam logic [CNT_W-1:0] C_DISC     = CNT_W'(T_DISC);

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_timer;
    logic [CNT_W-1:0] r_disc_cnt;
    logic             r_got_null;
    logic             r_first_bit;
    logic             r_rx_resetn;
    logic             r_enable_tx;
    logic             r_send_null_tx;
    logic             r_send_fct_tx;
    logic             r_link_run;
    logic             r_link_error;

    logic w_got_null;
    logic w_disconnect;
    logic w_link_en;
    logic w_t_done;
    logic w_err_c;
    logic w_rx_resetn;
    logic w_enable_tx;
    logic w_send_null_tx;
    logic w_send_fct_tx;
    logic w_link_run;

    // A NULL arriving this cycle already counts, so a simultaneous FCT is legal.
    assign w_got_null   = r_got_null | (lnk.rx_got_null & r_rx_resetn);
    assign w_disconnect = r_first_bit && (r_disc_cnt == C_DISC);
    assign w_link_en    = !lnk.link_disable &&
                          (lnk.link_start || (lnk.auto_start && r_got_null));

    // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        w_t_done = 1'b0;
        w_err_c  = 1'b0;
        case (r_state)
            ERROR_RESET: w_t_done = (r_timer == C_T6_LAST);
            ERROR_WAIT, READY, STARTED: begin
                w_t_done = (r_state != READY) && (r_timer == C_T12_LAST);
                w_err_c  = lnk.rx_error || w_disconnect ||
                           (lnk.rx_got_fct && !w_got_null) ||
                           lnk.rx_got_nchar || lnk.rx_got_time_code;
            end
            CONNECTING: begin
                w_t_done = (r_timer == C_T12_LAST);
                w_err_c  = lnk.rx_error || w_disconnect ||
                           lnk.rx_got_nchar || lnk.rx_got_time_code;
            end
            RUN:     w_err_c = lnk.rx_error || w_disconnect || lnk.credit_error;
            default: w_err_c = 1'b0;
        endcase
    end

    // Next state: error first, then link_disable in RUN, then timeout, then progress.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ERROR_RESET: if (w_t_done) w_next = ERROR_WAIT;
            ERROR_WAIT: begin
                if (w_err_c)       w_next = ERROR_RESET;
                else if (w_t_done) w_next = READY;
            end
            READY: begin
                if (w_err_c)        w_next = ERROR_RESET;
                else if (w_link_en) w_next = STARTED;
            end
            STARTED: begin
                if (w_err_c || w_t_done) w_next = ERROR_RESET;
                else if (r_got_null)     w_next = CONNECTING;
            end
            CONNECTING: begin
                if (w_err_c || w_t_done) w_next = ERROR_RESET;
                else if (lnk.rx_got_fct) w_next = RUN;
            end
            RUN:     if (w_err_c || lnk.link_disable) w_next = ERROR_RESET;
            default: w_next = ERROR_RESET;
        endcase
    end

    always_comb begin
        w_rx_resetn    = (w_next != ERROR_RESET);
        w_enable_tx    = (w_next == STARTED) || (w_next == CONNECTING) || (w_next == RUN);
        w_send_null_tx = (w_next == STARTED);
        w_send_fct_tx  = (w_next == CONNECTING) || (w_next == RUN);
        w_link_run     = (w_next == RUN);
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge pclk or negedge resetn) begin
        if (!resetn) begin
            r_state <= ERROR_RESET;
            r_timer <= '0;
        end else begin
            r_state <= w_next;
            r_timer <= (w_next != r_state) ? '0 : r_timer + CNT_W'(1);
        end
    end

    always_ff @(posedge pclk or negedge resetn) begin
        if (!resetn) begin
            r_rx_resetn    <= 1'b0;
            r_enable_tx    <= 1'b0;
            r_send_null_tx <= 1'b0;
            r_send_fct_tx  <= 1'b0;
            r_link_run     <= 1'b0;
            r_link_error   <= 1'b0;
        end else begin
            r_rx_resetn    <= w_rx_resetn;
            r_enable_tx    <= w_enable_tx;
            r_send_null_tx <= w_send_null_tx;
            r_send_fct_tx  <= w_send_fct_tx;
            r_link_run     <= w_link_run;
            r_link_error   <= (w_next == ERROR_RESET) && (r_state != ERROR_RESET);
        end
    end

    // Sticky receive flags only latch while the receiver is out of reset.
    always_ff @(posedge pclk or negedge resetn) begin
        if (!resetn) begin
            r_got_null  <= 1'b0;
            r_first_bit <= 1'b0;
            r_disc_cnt  <= '0;
        end else begin
            if (r_state == ERROR_RESET) begin
                r_got_null  <= 1'b0;
                r_first_bit <= 1'b0;
            end else begin
                if (lnk.rx_got_null && r_rx_resetn) r_got_null  <= 1'b1;
                if (lnk.rx_got_bit && r_rx_resetn)  r_first_bit <= 1'b1;
            end
            if (lnk.rx_got_bit)          r_disc_cnt <= '0;
            else if (r_disc_cnt != C_DISC) r_disc_cnt <= r_disc_cnt + CNT_W'(1);
        end
    end

    assign lnk.fsm_state    = r_state;
    assign lnk.rx_resetn    = r_rx_resetn;
    assign lnk.enable_tx    = r_enable_tx;
    assign lnk.send_null_tx = r_send_null_tx;
    assign lnk.send_fct_tx  = r_send_fct_tx;
    assign lnk.link_run     = r_link_run;
    assign lnk.link_error   = r_link_error;

endmodule

// File: tb/tb_spw_link_fsm.sv
// Scoreboard bench for spw_link_fsm: stimulus queues each expected state or
// link_error change with its cycle; a monitor pops and compares on every change.
module tb_spw_link_fsm;

    localparam logic [2:0] ST_ER = 3'd0, ST_EW = 3'd1, ST_RDY = 3'd2,
                           ST_STA = 3'd3, ST_CON = 3'd4, ST_RUN = 3'd5;

    typedef struct {
        int         cyc;
        logic [2:0] st;
        logic       err;
    } ev_t;

    logic pclk;
    logic resetn;
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;
    ev_t  q[$];

    spw_link_fsm_if lnk ();

    spw_link_fsm dut (
        .pclk   (pclk),
        .resetn (resetn),
        .lnk    (lnk)
    );

    initial begin
        pclk = 1'b0;
        forever #5 pclk = ~pclk;
    end

    always @(posedge pclk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d (cyc %0d)", name, got, exp, cyc);
        end
    endtask

    // {rx_resetn, enable_tx, send_null_tx, send_fct_tx, link_run} per state
    function automatic logic [4:0] exp_out(input logic [2:0] st);
        case (st)
            ST_EW, ST_RDY: return 5'b10000;
            ST_STA:        return 5'b11100;
            ST_CON:        return 5'b11010;
            ST_RUN:        return 5'b11011;
            default:       return 5'b00000;
        endcase
    endfunction

    task automatic push(input int c, input logic [2:0] st, input logic err);
        ev_t e;
        e.cyc = c;
        e.st  = st;
        e.err = err;
        q.push_back(e);
    endtask

    task automatic wait_to(input int t);
        while (cyc < t) @(negedge pclk);
    endtask

    // Monitor: any change of state or link_error is one DUT event.
    initial begin
        logic [3:0] prev;
        logic [3:0] obs;
        ev_t        e;
        prev = 4'b0;
        #5;
        forever begin
            @(negedge pclk);
            obs = {lnk.fsm_state, lnk.link_error};
            if (obs !== prev) begin
                check("event_expected", q.size(), (q.size() == 0) ? 1 : q.size());
                if (q.size() != 0) begin
                    e = q.pop_front();
                    check("event_cycle", cyc, e.cyc);
                    check("event_state", lnk.fsm_state, e.st);
                    check("event_link_error", lnk.link_error, e.err);
                    check("event_outputs",
                          {lnk.rx_resetn, lnk.enable_tx, lnk.send_null_tx,
                           lnk.send_fct_tx, lnk.link_run}, exp_out(e.st));
                end
                prev = obs;
            end
        end
    end

    initial begin
        int t;
        resetn = 1'b1;
        lnk.link_start = 0; lnk.auto_start = 0; lnk.link_disable = 0;
        lnk.rx_got_bit = 0; lnk.rx_got_null = 0; lnk.rx_got_fct = 0;
        lnk.rx_got_nchar = 0; lnk.rx_got_time_code = 0;
        lnk.rx_error = 0; lnk.credit_error = 0;
        #1 resetn = 1'b0;
        repeat (3) @(negedge pclk);
        check("reset_values",
              {lnk.fsm_state, lnk.link_error, lnk.rx_resetn, lnk.enable_tx,
               lnk.send_null_tx, lnk.send_fct_tx, lnk.link_run}, 0);

        // Reset release with no RX activity.
        t = cyc;
        resetn = 1'b1;
        push(t + 64, ST_EW, 0);
        push(t + 192, ST_RDY, 0);
        wait_to(t + 200);

        // Normal bring-up with link_start.
        t = cyc;
        lnk.link_start = 1;
        push(t + 1, ST_STA, 0);
        wait_to(t + 5);  lnk.rx_got_bit = 1; lnk.rx_got_null = 1;
        push(t + 7, ST_CON, 0);
        wait_to(t + 6);  lnk.rx_got_null = 0;
        wait_to(t + 10); lnk.rx_got_fct = 1;
        push(t + 11, ST_RUN, 0);
        wait_to(t + 11); lnk.rx_got_fct = 0;
        wait_to(t + 20);

        // Disconnect in RUN, automatic restart, then STARTED timeout.
        t = cyc;
        lnk.rx_got_bit = 0;
        push(t + 10, ST_ER, 1);  push(t + 11, ST_ER, 0);
        push(t + 74, ST_EW, 0);  push(t + 202, ST_RDY, 0);
        push(t + 203, ST_STA, 0);
        push(t + 331, ST_ER, 1); push(t + 332, ST_ER, 0);
        wait_to(t + 340); lnk.link_start = 0;
        push(t + 395, ST_EW, 0); push(t + 523, ST_RDY, 0);
        wait_to(t + 530);

        // auto_start waits for a NULL; credit_error then link_disable in RUN.
        t = cyc;
        lnk.auto_start = 1; lnk.rx_got_bit = 1;
        wait_to(t + 5);   lnk.rx_got_null = 1;
        push(t + 7, ST_STA, 0);  push(t + 8, ST_CON, 0);
        wait_to(t + 6);   lnk.rx_got_null = 0;
        wait_to(t + 12);  lnk.rx_got_fct = 1;
        push(t + 13, ST_RUN, 0);
        wait_to(t + 13);  lnk.rx_got_fct = 0;
        wait_to(t + 20);  lnk.credit_error = 1;
        push(t + 21, ST_ER, 1);  push(t + 22, ST_ER, 0);
        wait_to(t + 21);  lnk.credit_error = 0;
        push(t + 85, ST_EW, 0);  push(t + 213, ST_RDY, 0);
        wait_to(t + 220); lnk.rx_got_null = 1;
        push(t + 222, ST_STA, 0); push(t + 223, ST_CON, 0);
        wait_to(t + 221); lnk.rx_got_null = 0;
        wait_to(t + 225); lnk.rx_got_fct = 1;
        push(t + 226, ST_RUN, 0);
        wait_to(t + 226); lnk.rx_got_fct = 0;
        wait_to(t + 230); lnk.link_disable = 1;
        push(t + 231, ST_ER, 1); push(t + 232, ST_ER, 0);
        wait_to(t + 231); lnk.link_disable = 0; lnk.auto_start = 0;
        push(t + 295, ST_EW, 0);

        // N-Char in ERROR_WAIT at its cycle 10.
        wait_to(t + 305); lnk.rx_got_nchar = 1;
        push(t + 306, ST_ER, 1); push(t + 307, ST_ER, 0);
        wait_to(t + 306); lnk.rx_got_nchar = 0;
        push(t + 370, ST_EW, 0); push(t + 498, ST_RDY, 0);

        // NULL+FCT together in STARTED is legal; rx_error beats FCT in CONNECTING.
        wait_to(t + 505); lnk.link_start = 1;
        push(t + 506, ST_STA, 0);
        wait_to(t + 510); lnk.rx_got_null = 1; lnk.rx_got_fct = 1;
        push(t + 512, ST_CON, 0);
        wait_to(t + 511); lnk.rx_got_null = 0; lnk.rx_got_fct = 0;
        wait_to(t + 515); lnk.rx_error = 1; lnk.rx_got_fct = 1;
        push(t + 516, ST_ER, 1); push(t + 517, ST_ER, 0);
        wait_to(t + 516); lnk.rx_error = 0; lnk.rx_got_fct = 0; lnk.link_start = 0;
        push(t + 580, ST_EW, 0); push(t + 708, ST_RDY, 0);

        // Asynchronous reset mid-operation: no link_error pulse.
        wait_to(t + 715); lnk.link_start = 1;
        push(t + 716, ST_STA, 0);
        wait_to(t + 720);
        push(t + 721, ST_ER, 0);
        #2 resetn = 1'b0; lnk.link_start = 0;
        wait_to(t + 723); resetn = 1'b1;
        push(t + 787, ST_EW, 0);
        wait_to(t + 800);

        check("events_outstanding", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
